// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache. Hits return the instruction
// combinationally; a miss stalls fetch while one line refills from backing memory.
module instr_cache #(
  parameter int DATA_WIDTH     = 32,
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  stall,
  output logic                  mem_req,
  output logic [DATA_WIDTH-1:0] mem_addr,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int OB = $clog2(WORDS_PER_LINE) + 2;
  localparam int IB = $clog2(LINES);
  localparam int TW = DATA_WIDTH - OB - IB;
  localparam int BW = $clog2(WORDS_PER_LINE);
  localparam logic [BW-1:0] LAST_BEAT = BW'(WORDS_PER_LINE - 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [LINES-1:0]      valid_q, valid_d;
  logic [TW-1:0]         tag_q  [LINES];
  logic [TW-1:0]         tag_d  [LINES];
  logic [DATA_WIDTH-1:0] data_q [LINES][WORDS_PER_LINE];
  logic [DATA_WIDTH-1:0] data_d [LINES][WORDS_PER_LINE];
  logic [BW-1:0]         beat_q, beat_d;
  logic                  abort_q, abort_d;
  logic [DATA_WIDTH-1:0] base_q, base_d;
  logic [IB-1:0]         fill_idx_q, fill_idx_d;

  logic [BW-1:0]         pc_word_s;
  logic [IB-1:0]         pc_idx_s;
  logic [TW-1:0]         pc_tag_s;
  logic                  hit_s;
  logic [1:0]            pc_byte_unused_s;

  assign pc_word_s        = pc[OB-1:2];
  assign pc_idx_s         = pc[OB+IB-1:OB];
  assign pc_tag_s         = pc[DATA_WIDTH-1:OB+IB];
  assign pc_byte_unused_s = pc[1:0];
  assign hit_s = (state_q == IDLE) && valid_q[pc_idx_s] && (tag_q[pc_idx_s] == pc_tag_s);

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      valid_q    <= {LINES{1'b0}};
      beat_q     <= {BW{1'b0}};
      abort_q    <= 1'b0;
      base_q     <= {DATA_WIDTH{1'b0}};
      fill_idx_q <= {IB{1'b0}};
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      beat_q     <= beat_d;
      abort_q    <= abort_d;
      base_q     <= base_d;
      fill_idx_q <= fill_idx_d;
    end
  end

  // Tag and data arrays are never reset; the valid bits gate their use.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  // Next-state and refill datapath.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    abort_d    = abort_q;
    base_d     = base_q;
    fill_idx_d = fill_idx_q;
    tag_d      = tag_q;
    data_d     = data_q;
    if (flush) begin
      valid_d = {LINES{1'b0}};
    end else begin
      valid_d = valid_q;
    end
    case (state_q)
      IDLE: begin
        if (!hit_s) begin
          state_d    = REFILL;
          base_d     = {pc_tag_s, pc_idx_s, {OB{1'b0}}};
          fill_idx_d = pc_idx_s;
          beat_d     = {BW{1'b0}};
          abort_d    = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      REFILL: begin
        if (flush) begin
          abort_d = 1'b1;
        end else begin
          abort_d = abort_q;
        end
        if (mem_ready) begin
          data_d[fill_idx_q][beat_q] = mem_rdata;
          beat_d = beat_q + {{(BW-1){1'b0}}, 1'b1};
          if (beat_q == LAST_BEAT) begin
            tag_d[fill_idx_q] = base_q[DATA_WIDTH-1:OB+IB];
            // A flush seen during the refill (or on its final beat) leaves the line invalid.
            if (!abort_q && !flush) begin
              valid_d[fill_idx_q] = 1'b1;
            end else begin
              valid_d[fill_idx_q] = 1'b0;
            end
            state_d = IDLE;
          end else begin
            state_d = REFILL;
          end
        end else begin
          state_d = REFILL;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Fetch and memory-side outputs; mem_* depend only on registered state.
  always_comb begin
    stall = ~hit_s;
    if (hit_s) begin
      instr = data_q[pc_idx_s][pc_word_s];
    end else begin
      instr = {DATA_WIDTH{1'b0}};
    end
    if (state_q == REFILL) begin
      mem_req  = 1'b1;
      mem_addr = base_q + DATA_WIDTH'({beat_q, 2'b00});
    end else begin
      mem_req  = 1'b0;
      mem_addr = {DATA_WIDTH{1'b0}};
    end
  end

endmodule

// File: tb/tb_instr_cache.sv
// Scoreboard bench for instr_cache: stimulus queues expected fetch results and
// refill beat addresses, a negedge monitor pops and compares them.
module tb_instr_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        mem_ready;
  logic [31:0] pc;
  logic [31:0] mem_rdata;
  logic [31:0] instr;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;

  int          n_checks = 0;
  int          n_pass   = 0;
  bit          hit_chk  = 1'b0;
  logic [31:0] exp_instr_q[$];
  logic [31:0] exp_addr_q[$];

  instr_cache #(.DATA_WIDTH(32), .LINES(16), .WORDS_PER_LINE(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .pc       (pc),
    .flush    (flush),
    .instr    (instr),
    .stall    (stall),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: compares every presented fetch result and every refill beat.
  always @(negedge clk) begin
    if (hit_chk) begin
      if (stall === 1'b0) begin
        if (exp_instr_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_hit: got instr 0x%08h, expected none", instr);
        end else begin
          check("instr", instr, exp_instr_q.pop_front());
        end
      end else begin
        check("instr_zero_when_stalled", instr, 32'h0);
      end
    end
    if (mem_req === 1'b1) begin
      if (exp_addr_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_mem_req: got addr 0x%08h, expected no request", mem_addr);
      end else if (mem_ready) begin
        check("mem_addr_beat", mem_addr, exp_addr_q.pop_front());
      end else begin
        check("mem_addr_hold", mem_addr, exp_addr_q[0]);
      end
    end
  end

  // Fetch address a; expect exp_pen stall cycles and n_refill line refills.
  // flush_at: cycle index to pulse flush (-1 none); pat/plen: mem_ready pattern per REFILL cycle.
  task automatic access(input logic [31:0] a, input int exp_pen, input int n_refill,
                        input int flush_at, input logic [15:0] pat, input int plen);
    int cyc;
    logic [31:0] base;
    @(posedge clk); #1;
    base = a & 32'hFFFF_FFF0;
    for (int r = 0; r < n_refill; r++)
      for (int b = 0; b < 4; b++) exp_addr_q.push_back(base + 32'(4 * b));
    exp_instr_q.push_back((a & 32'hFFFF_FFFC) + 32'h100);
    rst       = 1'b0;
    pc        = a;
    mem_ready = 1'b1;
    flush     = (flush_at == 0);
    hit_chk   = 1'b1;
    cyc       = 0;
    while (1) begin
      @(negedge clk);
      if (stall === 1'b0 || cyc >= 60) break;
      cyc++;
      @(posedge clk); #1;
      mem_ready = (cyc - 1 < plen) ? pat[cyc-1] : 1'b1;
      mem_rdata = mem_addr + 32'h100;
      flush     = (cyc == flush_at);
    end
    flush = 1'b0;
    check($sformatf("stall_cycles@%08h", a), 32'(cyc), 32'(exp_pen));
  endtask

  task automatic flush_pulse();
    @(posedge clk); #1;
    hit_chk = 1'b0;
    flush   = 1'b1;
  endtask

  // Start a refill of line a, assert rst while beat 2 is on the bus.
  task automatic reset_mid_refill(input logic [31:0] a);
    @(posedge clk); #1;
    hit_chk   = 1'b0;
    pc        = a;
    mem_ready = 1'b1;
    flush     = 1'b0;
    for (int b = 0; b < 3; b++) exp_addr_q.push_back(a + 32'(4 * b));
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      mem_rdata = mem_addr + 32'h100;
      if (c == 3) rst = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    check("mem_req_after_rst", 32'(mem_req), 32'h0);
    check("mem_addr_after_rst", mem_addr, 32'h0);
    check("stall_after_rst", 32'(stall), 32'h1);
  endtask

  initial begin
    rst       = 1'b1;
    pc        = 32'h0;
    flush     = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_mem_req", 32'(mem_req), 32'h0);
    check("reset_mem_addr", mem_addr, 32'h0);
    check("reset_stall", 32'(stall), 32'h1);
    check("reset_instr", instr, 32'h0);

    // Cold miss then hits on the rest of the line.
    access(32'h0000_0000, 5, 1, -1, 16'h0, 0);
    access(32'h0000_0004, 0, 0, -1, 16'h0, 0);
    access(32'h0000_0008, 0, 0, -1, 16'h0, 0);
    access(32'h0000_000C, 0, 0, -1, 16'h0, 0);
    // Conflict misses on index 0.
    access(32'h0000_0100, 5, 1, -1, 16'h0, 0);
    access(32'h0000_0000, 5, 1, -1, 16'h0, 0);
    // Wait states 1,0,0,1,1,0,1.
    access(32'h0000_0020, 8, 1, -1, 16'b1011001, 7);
    // Flush while idle.
    access(32'h0000_0000, 0, 0, -1, 16'h0, 0);
    flush_pulse();
    access(32'h0000_0000, 5, 1, -1, 16'h0, 0);
    // Flush during beat 2: line completes invalid, second refill follows.
    access(32'h0000_0030, 10, 2, 3, 16'h0, 0);
    access(32'h0000_0034, 0, 0, -1, 16'h0, 0);
    // Flush coinciding with an idle miss: new line still validates.
    access(32'h0000_0050, 5, 1, 0, 16'h0, 0);
    access(32'h0000_0054, 0, 0, -1, 16'h0, 0);
    access(32'h0000_0030, 5, 1, -1, 16'h0, 0);
    // Reset mid-refill.
    reset_mid_refill(32'h0000_0040);
    access(32'h0000_0040, 5, 1, -1, 16'h0, 0);
    access(32'h0000_004C, 0, 0, -1, 16'h0, 0);
    // Misaligned fetch.
    access(32'h0000_0012, 5, 1, -1, 16'h0, 0);

    @(posedge clk); #1;
    hit_chk = 1'b0;
    check("instr_queue_drained", 32'(exp_instr_q.size()), 32'h0);
    check("addr_queue_drained", 32'(exp_addr_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
